// File: rtl/fxp_requant_pkg.sv
// Shared types and defaults for the fxp_requant requantiser slice.
package fxp_requant_pkg;

  localparam int FXP_MAX_WIDTH         = 64;
  localparam int FXP_REQUANT_IN_W      = 40;
  localparam int FXP_REQUANT_OUT_W     = 20;
  localparam int FXP_REQUANT_MAX_SHIFT = 31;
  localparam int FXP_REQUANT_N_CH      = 2;

  typedef enum logic [1:0] {
    RND_TRUNC     = 2'd0,
    RND_HALF_UP   = 2'd1,
    RND_CONV      = 2'd2,
    RND_HALF_AWAY = 2'd3
  } rnd_mode_e;

  // Limit a requested shift to the largest supported amount.
  function automatic int unsigned fxp_clamp_shift(input int unsigned sh, input int unsigned max_sh);
    if (sh > max_sh) begin
      return max_sh;
    end else begin
      return sh;
    end
  endfunction

endpackage

// File: rtl/fxp_requant_lane.sv
// One requantiser lane: S1 adds the rounding bias, S2 shifts and saturates.
// Flow control lives in the parent; this lane only loads when told to.
module fxp_requant_lane
  import fxp_requant_pkg::*;
#(
  parameter int IN_W  = FXP_REQUANT_IN_W,
  parameter int OUT_W = FXP_REQUANT_OUT_W,
  parameter int SH_W  = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             s1_en,
  input  logic             s2_en,
  input  logic [IN_W-1:0]  in_x,
  input  logic [SH_W-1:0]  in_shift,
  input  rnd_mode_e        in_mode,
  input  logic [SH_W-1:0]  s2_shift,
  output logic [OUT_W-1:0] out_dat,
  output logic             out_sat
);

  localparam logic signed [IN_W:0] ONE_S = {{IN_W{1'b0}}, 1'b1};
  localparam logic signed [IN_W:0] MAX_V = {{(IN_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W:0] MIN_V = {{(IN_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};
  localparam logic [SH_W-1:0]      SH_ONE = {{(SH_W-1){1'b0}}, 1'b1};

  logic signed [IN_W:0] x_ext_s;
  logic signed [IN_W:0] h_s;
  logic signed [IN_W:0] bias_s;
  logic signed [IN_W:0] sum_d, sum_q;
  logic signed [IN_W:0] r_s;
  logic [OUT_W-1:0]     dat_d, dat_q;
  logic                 sat_d, sat_q;

  // S1: bias selection; the extra MSB keeps x + bias from overflowing.
  always_comb begin
    x_ext_s = {in_x[IN_W-1], in_x};
    h_s     = '0;
    bias_s  = '0;
    if (in_shift != '0) begin
      h_s = ONE_S << (in_shift - SH_ONE);
      case (in_mode)
        RND_TRUNC:     bias_s = '0;
        RND_HALF_UP:   bias_s = h_s;
        RND_CONV:      bias_s = h_s - ONE_S + {{IN_W{1'b0}}, x_ext_s[in_shift]};
        RND_HALF_AWAY: bias_s = x_ext_s[IN_W] ? (h_s - ONE_S) : h_s;
        default:       bias_s = '0;
      endcase
    end else begin
      bias_s = '0;
    end
    if (s1_en) begin
      sum_d = x_ext_s + bias_s;
    end else begin
      sum_d = sum_q;
    end
  end

  // S2: arithmetic shift then clamp to the signed output range.
  always_comb begin
    r_s   = sum_q >>> s2_shift;
    dat_d = dat_q;
    sat_d = sat_q;
    if (s2_en) begin
      if (r_s > MAX_V) begin
        dat_d = MAX_V[OUT_W-1:0];
        sat_d = 1'b1;
      end else if (r_s < MIN_V) begin
        dat_d = MIN_V[OUT_W-1:0];
        sat_d = 1'b1;
      end else begin
        dat_d = r_s[OUT_W-1:0];
        sat_d = 1'b0;
      end
    end else begin
      dat_d = dat_q;
      sat_d = sat_q;
    end
  end

  // Stage registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= '0;
      dat_q <= '0;
      sat_q <= 1'b0;
    end else begin
      sum_q <= sum_d;
      dat_q <= dat_d;
      sat_q <= sat_d;
    end
  end

  assign out_dat = dat_q;
  assign out_sat = sat_q;

endmodule

// File: rtl/fxp_requant.sv
// Multi-lane two-stage requantiser with valid/ready flow control.
// Define FXP_REQUANT_STICKY_EN to build the sticky per-lane saturation flags.
module fxp_requant
  import fxp_requant_pkg::*;
#(
  parameter  int IN_W      = FXP_REQUANT_IN_W,
  parameter  int OUT_W     = FXP_REQUANT_OUT_W,
  parameter  int MAX_SHIFT = FXP_REQUANT_MAX_SHIFT,
  parameter  int N_CH      = FXP_REQUANT_N_CH,
  localparam int SH_W      = $clog2(MAX_SHIFT + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N_CH*IN_W-1:0]  in_dat,
  input  logic [SH_W-1:0]       in_shift,
  input  rnd_mode_e             in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [N_CH*OUT_W-1:0] out_dat,
  output logic [N_CH-1:0]       out_sat,
  input  logic                  sat_clr,
  output logic [N_CH-1:0]       sat_sticky
);

  logic            s1_vld_d, s1_vld_q;
  logic            s2_vld_d, s2_vld_q;
  logic            s1_rdy_s, s2_rdy_s;
  logic            s1_en_s, s2_en_s;
  logic [SH_W-1:0] shift_c_s;
  logic [SH_W-1:0] s1_shift_d, s1_shift_q;

  // Ready chain and stage-valid next state; a stage advances when the next one can take it.
  always_comb begin
    s2_rdy_s  = ~s2_vld_q | out_ready;
    s1_rdy_s  = ~s1_vld_q | s2_rdy_s;
    s1_en_s   = in_valid & s1_rdy_s;
    s2_en_s   = s1_vld_q & s2_rdy_s;
    shift_c_s = SH_W'(fxp_clamp_shift(32'(in_shift), MAX_SHIFT));
    if (s1_rdy_s) begin
      s1_vld_d = in_valid;
    end else begin
      s1_vld_d = s1_vld_q;
    end
    if (s2_rdy_s) begin
      s2_vld_d = s1_vld_q;
    end else begin
      s2_vld_d = s2_vld_q;
    end
    if (s1_en_s) begin
      s1_shift_d = shift_c_s;
    end else begin
      s1_shift_d = s1_shift_q;
    end
  end

  // Stage valids and the shift carried into S2.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_q   <= 1'b0;
      s2_vld_q   <= 1'b0;
      s1_shift_q <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s2_vld_q   <= s2_vld_d;
      s1_shift_q <= s1_shift_d;
    end
  end

  assign in_ready  = s1_rdy_s;
  assign out_valid = s2_vld_q;

  for (genvar i = 0; i < N_CH; i++) begin : g_lane
    fxp_requant_lane #(
      .IN_W  (IN_W),
      .OUT_W (OUT_W),
      .SH_W  (SH_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .s1_en    (s1_en_s),
      .s2_en    (s2_en_s),
      .in_x     (in_dat[i*IN_W +: IN_W]),
      .in_shift (shift_c_s),
      .in_mode  (in_mode),
      .s2_shift (s1_shift_q),
      .out_dat  (out_dat[i*OUT_W +: OUT_W]),
      .out_sat  (out_sat[i])
    );
  end

`ifdef FXP_REQUANT_STICKY_EN
  logic [N_CH-1:0] sticky_d, sticky_q;

  // Sticky flags: a clear and a new saturation in the same cycle leaves the flag set.
  always_comb begin
    sticky_d = sticky_q;
    if (sat_clr) begin
      sticky_d = '0;
    end else begin
      sticky_d = sticky_q;
    end
    if (out_valid & out_ready) begin
      sticky_d = sticky_d | out_sat;
    end else begin
      sticky_d = sticky_d;
    end
  end

  // Sticky flag register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sat_sticky = sticky_q;
`else
  logic sticky_unused;
  assign sticky_unused = sat_clr;
  assign sat_sticky    = '0;
`endif

endmodule
